mag_pow_gen: RTL and testbench



---
 rtl/mag_pow_gen.sv | 95 +++++++++
 tb/tb_mag_pow_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mag_pow_gen.sv
// Magnitude-power basis generator: streams |x| and emits the aligned power vector
// |x|^0 .. |x|^(NPOW-1) in unsigned Q1.(W-1), saturating instead of wrapping.
module mag_pow_gen #(
  parameter int W    = 20,
  parameter int NPOW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        mag_in,
  input  logic                mag_valid,
  input  logic                sat_clr,
  output logic [NPOW*W-1:0]   pow_out,
  output logic                pow_valid,
  output logic [NPOW-1:0]     sat_flag
);

  // Chain depth: one register per product, at least one stage even when NPOW=2.
  localparam int D = (NPOW - 2 > 1) ? (NPOW - 2) : 1;
  localparam logic [W-1:0] UNITY = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAXV  = '1;

  // Q1.(W-1) product with round-half-up; returns {sat_event, result}.
  function automatic logic [W:0] mul_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    logic [W:0]     r;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r    = {1'b0, full[2*W-2:W-1]} + {{W{1'b0}}, full[W-2]};
    if (full[2*W-1] || r[W]) return {1'b1, MAXV};
    return {1'b0, r[W-1:0]};
  endfunction

  for (genvar s = 1; s <= D; s++) begin : g_stage
    logic [W-1:0]    p     [1:NPOW-1];
    logic [NPOW-1:0] sat;
    logic            v;
    logic [W-1:0]    in_p  [1:NPOW-1];
    logic [NPOW-1:0] in_sat;
    logic            in_v;

    if (s == 1) begin : g_first
      always_comb begin
        in_p    = '{default: '0};
        in_p[1] = mag_in;
        in_sat  = '0;
        in_v    = mag_valid;
      end
    end else begin : g_chain
      assign in_p   = g_stage[s-1].p;
      assign in_sat = g_stage[s-1].sat;
      assign in_v   = g_stage[s-1].v;
    end

    // Stage s forms p(s+1) from the previous power and the matching delayed p1;
    // every other slice just moves one register further down the chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 1; k < NPOW; k++) p[k] <= '0;
        sat <= '0;
        v   <= 1'b0;
      end else begin
        v   <= in_v;
        sat <= in_sat;
        for (int k = 1; k < NPOW; k++) p[k] <= in_p[k];
        for (int k = 2; k < NPOW; k++)
          if (k == s + 1) {sat[k], p[k]} <= mul_sat(in_p[k-1], in_p[1]);
      end
    end
  end

  logic [W-1:0]    last_p [1:NPOW-1];
  logic [NPOW-1:0] last_sat;
  logic            last_v;

  assign last_p   = g_stage[D].p;
  assign last_sat = g_stage[D].sat;
  assign last_v   = g_stage[D].v;

  // Output register: slices are zeroed on bubbles; a new saturation beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pow_out   <= '0;
      pow_valid <= 1'b0;
      sat_flag  <= '0;
    end else begin
      pow_valid <= last_v;
      pow_out   <= '0;
      if (last_v) begin
        pow_out[W-1:0] <= UNITY;
        for (int k = 1; k < NPOW; k++) pow_out[k*W +: W] <= last_p[k];
      end
      sat_flag <= (sat_clr ? '0 : sat_flag) | (last_v ? last_sat : '0);
    end
  end

endmodule

// File: tb/tb_mag_pow_gen.sv
// Scoreboarded bench for mag_pow_gen: three instances (W20/NPOW5, W20/NPOW2,
// W16/NPOW8) share one stimulus stream and are checked against an arithmetic model.
module tb_mag_pow_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  mag_in;
  logic [15:0]  mag16;
  logic         mag_valid;
  logic         sat_clr;

  logic [99:0]  pow5;
  logic         pv5;
  logic [4:0]   sf5;
  logic [39:0]  pow2;
  logic         pv2;
  logic [1:0]   sf2;
  logic [127:0] pow8;
  logic         pv8;
  logic [7:0]   sf8;

  typedef struct {
    logic [159:0] pow;
    logic [7:0]   sat;
    int           cyc;
  } exp_t;

  exp_t        sbq [3][$];
  logic [7:0]  exp_flag [3];
  logic        clr_q;
  int          cyc;
  int          checks;
  int          failures;

  mag_pow_gen #(.W(20), .NPOW(5)) dut5 (
    .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid), .sat_clr(sat_clr),
    .pow_out(pow5), .pow_valid(pv5), .sat_flag(sf5));

  mag_pow_gen #(.W(20), .NPOW(2)) dut2 (
    .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid), .sat_clr(sat_clr),
    .pow_out(pow2), .pow_valid(pv2), .sat_flag(sf2));

  mag_pow_gen #(.W(16), .NPOW(8)) dut8 (
    .clk(clk), .rst(rst), .mag_in(mag16), .mag_valid(mag_valid), .sat_clr(sat_clr),
    .pow_out(pow8), .pow_valid(pv8), .sat_flag(sf8));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    clr_q <= sat_clr;
  end

  // Reference: repeated Q1.(w-1) multiply, rounded as floor((full + half) / 2^(w-1)),
  // clipped to 2^w-1 when it does not fit.
  function automatic exp_t model(input longint x, input int w, input int np, input int c);
    exp_t   e;
    longint prev, full, r, maxv;
    maxv  = (longint'(1) << w) - 1;
    e.pow = '0;
    e.sat = '0;
    e.cyc = c;
    e.pow = e.pow | 160'((longint'(1) << (w - 1)) - 1);
    e.pow = e.pow | (160'(x) << w);
    prev  = x;
    for (int k = 2; k < np; k++) begin
      full = prev * x;
      r    = (full + (longint'(1) << (w - 2))) >> (w - 1);
      if (r > maxv) begin
        r        = maxv;
        e.sat[k] = 1'b1;
      end
      e.pow = e.pow | (160'(r) << (k * w));
      prev  = r;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [19:0] m, input logic v, input logic clr);
    @(posedge clk);
    #1;
    mag_in    = m;
    mag16     = m[19:4];
    mag_valid = v;
    sat_clr   = clr;
    if (v) begin
      sbq[0].push_back(model(longint'(m), 20, 5, cyc + 4));
      sbq[1].push_back(model(longint'(m), 20, 2, cyc + 2));
      sbq[2].push_back(model(longint'(m[19:4]), 16, 8, cyc + 7));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(20'd0, 1'b0, 1'b0);
  endtask

  task automatic resetMidStream();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mag_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sbq[i].delete();
      exp_flag[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkOutput(input int id, input logic pv, input logic [159:0] po,
                             input logic [7:0] sf);
    exp_t e;
    while (sbq[id].size() > 0 && sbq[id][0].cyc < cyc) begin
      checks++;
      failures++;
      $display("[TB] FAIL missing_output dut%0d: got pow_valid=0 at cycle %0d, expected 1 at cycle %0d",
               id, cyc, sbq[id][0].cyc);
      void'(sbq[id].pop_front());
    end
    if (clr_q) exp_flag[id] = '0;
    checks++;
    if (pv) begin
      if (sbq[id].size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_valid dut%0d cycle %0d: got pow_valid=1, expected 0", id, cyc);
      end else begin
        e = sbq[id].pop_front();
        if (e.cyc != cyc || po !== e.pow) begin
          failures++;
          $display("[TB] FAIL pow_out dut%0d: got %h at cycle %0d, expected %h at cycle %0d",
                   id, po, cyc, e.pow, e.cyc);
        end
        exp_flag[id] = exp_flag[id] | e.sat;
      end
    end else if (po !== '0) begin
      failures++;
      $display("[TB] FAIL bubble_zero dut%0d cycle %0d: got %h, expected 0", id, cyc, po);
    end
    checks++;
    if (sf !== exp_flag[id]) begin
      failures++;
      $display("[TB] FAIL sat_flag dut%0d cycle %0d: got %b, expected %b", id, cyc, sf, exp_flag[id]);
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, pv5, 160'(pow5), 8'(sf5));
    checkOutput(1, pv2, 160'(pow2), 8'(sf2));
    checkOutput(2, pv8, 160'(pow8), 8'(sf8));
  end

  initial begin
    rst       = 1'b1;
    mag_in    = '0;
    mag16     = '0;
    mag_valid = 1'b0;
    sat_clr   = 1'b0;
    clr_q     = 1'b0;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    for (int i = 0; i < 3; i++) exp_flag[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    applyStimulus(20'd524288, 1'b1, 1'b0);
    idle(9);
    applyStimulus(20'd262144, 1'b1, 1'b0);
    applyStimulus(20'd1536, 1'b1, 1'b0);
    applyStimulus(20'd1, 1'b1, 1'b0);
    idle(9);

    applyStimulus(20'd1048575, 1'b1, 1'b0);
    idle(8);
    applyStimulus(20'd0, 1'b0, 1'b1);
    idle(3);

    // Clear lands on the same edge the saturated sample reaches the NPOW=5 output.
    applyStimulus(20'd1048575, 1'b1, 1'b0);
    idle(2);
    applyStimulus(20'd0, 1'b0, 1'b1);
    idle(8);

    for (int i = 0; i < 100; i++) begin
      logic [19:0] m;
      case ($urandom_range(0, 3))
        0:       m = 20'($urandom_range(0, 1048575));
        1:       m = 20'($urandom_range(524200, 524400));
        2:       m = 20'($urandom_range(0, 4095));
        default: m = 20'($urandom_range(700000, 1048575));
      endcase
      applyStimulus(m, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(10);

    applyStimulus(20'd300000, 1'b1, 1'b0);
    applyStimulus(20'd1048575, 1'b1, 1'b0);
    applyStimulus(20'd400000, 1'b1, 1'b0);
    resetMidStream();
    idle(3);
    applyStimulus(20'd524288, 1'b1, 1'b0);
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
